ring_gather_engine: RTL and testbench
=====================================

// Module: ring_gather_engine
// PURPOSE
//  Synthesisable per-node gather traffic engine for the bidirectional ring NoC.
//  Replaces hand-written bench tasks. Parametrised in node count, round count and injection polarity.
//  In each phase p (destination node p) the node injects one packet toward p, taking the shortest path.
//  Receive side checks every ejected packet and counts it; one instance sits on each router PE port.
// PARAMETERS
//  PACKET_SIZE  64    packet width; layout {vc,dir,res[5:0],hop[7:0],src[15:0],payload[31:0]}
//  NUM_NODES    4     ring size, 2..16 (hop mask is 8 bits)
//  NODE_ID      0     this node's id, 0..NUM_NODES-1
//  NUM_ROUNDS   16    gather rounds (each round = NUM_NODES phases); 0 = run until stop
//  INJ_POL      0     polarity value in which this node may inject; also used as the vc field
//  CNT_W        32    width of the statistics counters
// PORTS
//  clk        in   1   clock
//  reset      in   1   asynchronous active-low reset
//  start      in   1   1-cycle pulse; IDLE->run; ignored when not IDLE
//  stop       in   1   finish the current phase, then go to DONE
//  polarity   in   1   router polarity; toggles every cycle after reset
//  peri       in   1   router ready to accept an injection
//  pesi       out  1   injection strobe, exactly 1 cycle per packet
//  pedi       out  64  injected packet
//  peso       in   1   ejected packet valid
//  pero       out  1   ready to take an ejected packet
//  pedo       in   64  ejected packet
//  busy       out  1   FSM not in IDLE/DONE
//  done       out  1   tx finished AND rx_count == (NUM_NODES-1)*NUM_ROUNDS; sticky until reset
//  phase      out  6   current phase id
//  tx_count   out  CNT_W  packets injected;  rx_count out CNT_W accepted;  err_count out CNT_W bad
// BEHAVIOUR
//  Reset: FSM=IDLE; pesi=0; pedi=0; pero=1; busy=0; done=0; phase=0; all counters 0.
//    Reset is async: pesi drops immediately, even mid-injection.
//  FSM: IDLE -start-> PHASE; PHASE -(phase==NODE_ID)-> NEXT, else WAIT_SLOT;
//       WAIT_SLOT -(polarity!=INJ_POL && peri at edge)-> SEND; SEND (1 cycle, pesi=1) -> NEXT;
//       NEXT: phase wraps at NUM_NODES-1 -> round++; last round or stop -> DONE, else PHASE.
//  SEND timing: pesi/pedi are registered, so pesi is high during a cycle where polarity==INJ_POL.
//  Packet: vc=INJ_POL, res=phase, src=NODE_ID, payload=phase.
//    d=(phase-NODE_ID) mod NUM_NODES; d<=NUM_NODES/2 -> dir=0 (cw), hops=d; else dir=1, hops=NUM_NODES-d.
//    Tie breaks clockwise. hop field = (1<<hops)-1 (thermometer, LSB first).
//  Latency: PHASE->pesi <= 3 cycles + slot wait. pedi holds its last value outside SEND.
//  Rx: packet accepted on peso&&pero at posedge; independent of tx, concurrent tx/rx allowed.
//    Error if payload!=NODE_ID, res!=NODE_ID, src>=NUM_NODES or src==NODE_ID. rx_count increments
//    on every accepted packet; err_count increments additionally on error.
//  Counters saturate at all-ones. NUM_ROUNDS=0 runs until stop; done then needs tx finished only.
//  start in DONE is ignored; only reset rearms the engine.
// CONFIGURATION
//  RING_GATHER_LATENCY_EN defined:
//    - free-running 8-bit cycle stamp written into src[15:8] on send.
//    - rx computes (stamp_now - src[15:8]) mod 256; extra outputs lat_max[7:0] and lat_sum[CNT_W-1:0].
//    - lat_max/lat_sum reset to 0 and update on error-free packets; src check uses src[7:0] only.
//  Not defined: src[15:8]=0, no latency ports or logic.
// STRUCTURE
//  Package ring_noc_pkg:
//    - field offsets/widths (VC_BIT, DIR_BIT, RES_LSB, HOP_LSB, SRC_LSB, PAYLOAD_LSB)
//    - DIR_CW=0 / DIR_CCW=1; FSM state typedef; function hop_mask(hops).
//  Sub-module ring_route_calc: combinational (src,dst,N) -> {dir,hop} and is reused by the router bench.
//  All other logic (FSM, rx checker, counters) stays in this module.
// TESTING
//  1. N=4, ID=0, ROUNDS=1, peri=1, start:
//     pedi = 0x0101_0000_0000_0001, 0x0203_0000_0000_0002, 0x4301_0000_0000_0003.
//     tx_count=3; no pesi in phase 0.
//  2. ID=2, INJ_POL=1: every pesi cycle has polarity==1 and vc=1. Phase 0 -> dir=0, hop=0x03.
//  3. peri=0 for 20 cycles in WAIT_SLOT: pesi stays 0, then fires in the first legal slot after peri=1.
//  4. Inject 3 good rx packets for ID=1 plus one with payload=2:
//     rx_count=4, err_count=1, done=0 until tx also finished.
//  5. Reset asserted during SEND: pesi=0 asynchronously, all outputs at reset values.
//     A new start runs a clean round.
//  6. RING_GATHER_LATENCY_EN, loopback with 5-cycle delay: lat_max=5; N=8 tie case d=4 -> dir=0, hop=0x0F.

Source files
------------

// File: rtl/ring_noc_pkg.sv
// ring_noc_pkg: packet field layout, ring direction codes, engine FSM states and the hop-mask helper
package ring_noc_pkg;
  localparam int VC_BIT = 63;
  localparam int DIR_BIT = 62;
  localparam int RES_LSB = 56;
  localparam int RES_W = 6;
  localparam int HOP_LSB = 48;
  localparam int HOP_W = 8;
  localparam int SRC_LSB = 32;
  localparam int SRC_W = 16;
  localparam int PAYLOAD_LSB = 0;
  localparam int PAYLOAD_W = 32;
  localparam logic DIR_CW = 1'b0;
  localparam logic DIR_CCW = 1'b1;
  typedef enum logic [2:0] {ST_IDLE, ST_PHASE, ST_WAIT_SLOT, ST_SEND, ST_NEXT, ST_DONE} state_e;
  function automatic logic [7:0] hop_mask(input logic [3:0] hops);
    return 8'((9'd1 << hops) - 9'd1);
  endfunction
endpackage

// File: rtl/ring_gather_engine_if.sv
// ring_gather_engine_if: router PE-port bundle.
//   polarity/peri/peso/pedo flow router->engine; pesi/pedi/pero flow engine->router.
//   master = engine side, slave = router (or bench) side.
interface ring_gather_engine_if #(parameter int PACKET_SIZE = 64);
  logic polarity, peri, pesi, peso, pero;
  logic [PACKET_SIZE-1:0] pedi, pedo;
  modport master (input polarity, peri, peso, pedo, output pesi, pedi, pero);
  modport slave (output polarity, peri, peso, pedo, input pesi, pedi, pero);
endinterface

// File: rtl/ring_route_calc.sv
// ring_route_calc: shortest-path route on an n-node bidirectional ring.
//   in: src, dst (node ids), n (ring size 2..16); out: dir (0 = cw), hop (thermometer mask, LSB first).
//   Equal distances break clockwise.
module ring_route_calc
  import ring_noc_pkg::*;
(
  input  logic [3:0] src,
  input  logic [3:0] dst,
  input  logic [4:0] n,
  output logic       dir,
  output logic [7:0] hop
);
  logic [4:0] d;
  logic [3:0] hops;
  always_comb begin
    d = dst >= src ? 5'(dst) - 5'(src) : 5'(dst) + n - 5'(src);
    dir = d > (n >> 1) ? DIR_CCW : DIR_CW;
    hops = 4'(dir == DIR_CCW ? n - d : d);
    hop = hop_mask(hops);
  end
endmodule

// File: rtl/ring_gather_engine.sv
// ring_gather_engine: per-node gather traffic generator and ejection checker for the ring NoC.
//   clk, reset (async, active low); start pulse arms, stop ends after the current phase.
//   pe (master): injection pesi/pedi gated by peri and polarity slots, ejection peso/pedo with pero.
//   busy/done/phase status; tx/rx/err counters saturate at all-ones.
//   Optional macro RING_GATHER_LATENCY_EN: cycle stamp in src[15:8], lat_max/lat_sum outputs.
module ring_gather_engine
  import ring_noc_pkg::*;
#(
  parameter int   PACKET_SIZE = 64,
  parameter int   NUM_NODES   = 4,
  parameter int   NODE_ID     = 0,
  parameter int   NUM_ROUNDS  = 16,
  parameter logic INJ_POL     = 1'b0,
  parameter int   CNT_W       = 32
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  ring_gather_engine_if.master pe,
  output logic                 busy,
  output logic                 done,
  output logic [5:0]           phase,
  output logic [CNT_W-1:0]     tx_count,
  output logic [CNT_W-1:0]     rx_count,
  output logic [CNT_W-1:0]     err_count
`ifdef RING_GATHER_LATENCY_EN
  ,
  output logic [7:0]           lat_max,
  output logic [CNT_W-1:0]     lat_sum
`endif
);
  localparam logic [CNT_W-1:0] RX_TARGET = CNT_W'((NUM_NODES - 1) * NUM_ROUNDS);
  state_e state_q, state_d;
  logic [5:0] phase_q, phase_d;
  logic [31:0] round_q, round_d;
  logic pesi_q, pesi_d, pero_q, pero_d, busy_q, busy_d, done_q, done_d, stop_q, stop_d;
  logic [PACKET_SIZE-1:0] pedi_q, pedi_d;
  logic [CNT_W-1:0] tx_q, tx_d, rx_q, rx_d, err_q, err_d;
  logic [63:0] pkt;
  logic [7:0] stamp, hop;
  logic [15:0] rx_src, rx_id;
  logic [5:0] rx_res;
  logic [31:0] rx_pay;
  logic dir, slot, send, wrap, last, accept, rx_bad, unused_hdr;
  ring_route_calc u_route (
    .src(4'(NODE_ID)),
    .dst(phase_q[3:0]),
    .n(5'(NUM_NODES)),
    .dir(dir),
    .hop(hop)
  );
  assign rx_src = pe.pedo[SRC_LSB +: SRC_W];
  assign rx_res = pe.pedo[RES_LSB +: RES_W];
  assign rx_pay = pe.pedo[PAYLOAD_LSB +: PAYLOAD_W];
  assign unused_hdr = ^pe.pedo[63:48];
`ifdef RING_GATHER_LATENCY_EN
  logic [7:0] stamp_q, stamp_d, lat, lat_max_q, lat_max_d;
  logic [CNT_W-1:0] lat_sum_q, lat_sum_d;
  logic [CNT_W:0] lat_acc;
  assign stamp = stamp_q;
  // The upper source byte carries the sender's stamp, so only the low byte identifies the node.
  assign rx_id = {8'd0, rx_src[7:0]};
  always_comb begin
    stamp_d = stamp_q + 8'd1;
    lat = stamp_q - rx_src[15:8];
    lat_acc = {1'b0, lat_sum_q} + (CNT_W + 1)'(lat);
    lat_max_d = accept && !rx_bad && lat > lat_max_q ? lat : lat_max_q;
    lat_sum_d = accept && !rx_bad ? (lat_acc[CNT_W] ? '1 : lat_acc[CNT_W-1:0]) : lat_sum_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      stamp_q <= '0;
      lat_max_q <= '0;
      lat_sum_q <= '0;
    end else begin
      stamp_q <= stamp_d;
      lat_max_q <= lat_max_d;
      lat_sum_q <= lat_sum_d;
    end
  assign lat_max = lat_max_q;
  assign lat_sum = lat_sum_q;
`else
  assign stamp = 8'd0;
  assign rx_id = rx_src;
`endif
  always_comb begin
    // A slot is taken when polarity is opposite to INJ_POL at the edge, so the registered
    // strobe lands in a cycle whose polarity equals INJ_POL.
    slot = pe.polarity != INJ_POL && pe.peri;
    wrap = phase_q == 6'(NUM_NODES - 1);
    last = NUM_ROUNDS != 0 && wrap && round_q == 32'(NUM_ROUNDS - 1);
    state_d = state_q;
    case (state_q)
      ST_IDLE:      state_d = start ? ST_PHASE : ST_IDLE;
      ST_PHASE:     state_d = phase_q == 6'(NODE_ID) ? ST_NEXT : ST_WAIT_SLOT;
      ST_WAIT_SLOT: state_d = slot ? ST_SEND : ST_WAIT_SLOT;
      ST_SEND:      state_d = ST_NEXT;
      ST_NEXT:      state_d = last || stop_q || stop ? ST_DONE : ST_PHASE;
      default:      state_d = state_q;
    endcase
    send = state_q == ST_WAIT_SLOT && slot;
    pkt = '0;
    pkt[VC_BIT] = INJ_POL;
    pkt[DIR_BIT] = dir;
    pkt[RES_LSB +: RES_W] = phase_q;
    pkt[HOP_LSB +: HOP_W] = hop;
    pkt[SRC_LSB +: SRC_W] = {stamp, 8'(NODE_ID)};
    pkt[PAYLOAD_LSB +: PAYLOAD_W] = 32'(phase_q);
    pesi_d = send;
    pedi_d = send ? PACKET_SIZE'(pkt) : pedi_q;
    pero_d = 1'b1;
    phase_d = state_q == ST_NEXT ? (wrap ? 6'd0 : phase_q + 6'd1) : phase_q;
    round_d = state_q == ST_NEXT && wrap ? round_q + 32'd1 : round_q;
    busy_d = state_d != ST_IDLE && state_d != ST_DONE;
    // Latch stop so a one-cycle pulse is honoured at the end of the phase.
    stop_d = busy_q && (stop_q || stop);
    accept = pe.peso && pero_q;
    rx_bad = rx_pay != 32'(NODE_ID) || rx_res != 6'(NODE_ID) ||
             rx_id >= 16'(NUM_NODES) || rx_id == 16'(NODE_ID);
    tx_d = send ? tx_q + CNT_W'(~&tx_q) : tx_q;
    rx_d = accept ? rx_q + CNT_W'(~&rx_q) : rx_q;
    err_d = accept && rx_bad ? err_q + CNT_W'(~&err_q) : err_q;
    done_d = done_q || (state_q == ST_DONE && (NUM_ROUNDS == 0 || rx_q == RX_TARGET));
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      round_q <= '0;
      pesi_q <= 1'b0;
      pedi_q <= '0;
      pero_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      stop_q <= 1'b0;
      tx_q <= '0;
      rx_q <= '0;
      err_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      round_q <= round_d;
      pesi_q <= pesi_d;
      pedi_q <= pedi_d;
      pero_q <= pero_d;
      busy_q <= busy_d;
      done_q <= done_d;
      stop_q <= stop_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      err_q <= err_d;
    end
  assign pe.pesi = pesi_q;
  assign pe.pedi = pedi_q;
  assign pe.pero = pero_q;
  assign busy = busy_q;
  assign done = done_q;
  assign phase = phase_q;
  assign tx_count = tx_q;
  assign rx_count = rx_q;
  assign err_count = err_q;
endmodule

// File: tb/tb_ring_gather_engine.sv
// tb_ring_gather_engine: directed bench for ring_gather_engine and ring_route_calc
`timescale 1ns/1ps
module tb_ring_gather_engine;
  localparam int CW = 32;
  logic clk = 1'b0, reset = 1'b1, polarity = 1'b0, start = 1'b0, stop = 1'b0, zero = 1'b0;
  logic [2:0] busy, done;
  logic [5:0] ph[3];
  logic [CW-1:0] tx[3], rx[3], er[3];
  logic [3:0] rc_src, rc_dst;
  logic [4:0] rc_n;
  logic rc_dir;
  logic [7:0] rc_hop;
  int n_cmp = 0, n_bad = 0, pol0bad = 0, pol2bad = 0;
  logic [63:0] cap0[$], cap2[$];
  typedef struct {logic [3:0] src, dst; logic [4:0] n; logic dir; logic [7:0] hop;} rvec_t;
  rvec_t rv[10];
  logic [63:0] exp0[3], exp2[3];
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    polarity = reset ? ~polarity : 1'b0;
  end
  ring_gather_engine_if if0(), if1(), if2();
  assign if0.polarity = polarity;
  assign if1.polarity = polarity;
  assign if2.polarity = polarity;
`ifdef RING_GATHER_LATENCY_EN
  logic [7:0] lm[4];
  logic [CW-1:0] ls[4], rx3, er3, tx3;
  logic [5:0] ph3;
  logic busy3, done3;
  logic [3:0] dv = '0;
  logic [63:0] dd[4];
  ring_gather_engine_if if3();
  assign if3.polarity = polarity;
  assign if3.peri = 1'b0;
  assign if3.peso = dv[3];
  assign if3.pedo = dd[3];
  always @(posedge clk) begin
    dv <= {dv[2:0], if0.pesi};
    dd[0] <= if0.pedi;
    for (int i = 1; i < 4; i++) dd[i] <= dd[i-1];
  end
  ring_gather_engine #(.NUM_NODES(4), .NODE_ID(1), .NUM_ROUNDS(1), .INJ_POL(1'b0)) u3 (
    .clk(clk), .reset(reset), .start(zero), .stop(zero), .pe(if3), .busy(busy3), .done(done3),
    .phase(ph3), .tx_count(tx3), .rx_count(rx3), .err_count(er3), .lat_max(lm[3]), .lat_sum(ls[3]));
`endif
  ring_gather_engine #(.NUM_NODES(4), .NODE_ID(0), .NUM_ROUNDS(1), .INJ_POL(1'b0)) u0 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .pe(if0), .busy(busy[0]), .done(done[0]),
    .phase(ph[0]), .tx_count(tx[0]), .rx_count(rx[0]), .err_count(er[0])
`ifdef RING_GATHER_LATENCY_EN
    , .lat_max(lm[0]), .lat_sum(ls[0])
`endif
  );
  ring_gather_engine #(.NUM_NODES(4), .NODE_ID(1), .NUM_ROUNDS(1), .INJ_POL(1'b0)) u1 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .pe(if1), .busy(busy[1]), .done(done[1]),
    .phase(ph[1]), .tx_count(tx[1]), .rx_count(rx[1]), .err_count(er[1])
`ifdef RING_GATHER_LATENCY_EN
    , .lat_max(lm[1]), .lat_sum(ls[1])
`endif
  );
  ring_gather_engine #(.NUM_NODES(4), .NODE_ID(2), .NUM_ROUNDS(1), .INJ_POL(1'b1)) u2 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .pe(if2), .busy(busy[2]), .done(done[2]),
    .phase(ph[2]), .tx_count(tx[2]), .rx_count(rx[2]), .err_count(er[2])
`ifdef RING_GATHER_LATENCY_EN
    , .lat_max(lm[2]), .lat_sum(ls[2])
`endif
  );
  ring_route_calc u_rc (.src(rc_src), .dst(rc_dst), .n(rc_n), .dir(rc_dir), .hop(rc_hop));
  always @(negedge clk) begin
    if (if0.pesi) begin
      cap0.push_back(if0.pedi);
      if (polarity != 1'b0) pol0bad++;
    end
    if (if2.pesi) begin
      cap2.push_back(if2.pedi);
      if (polarity != 1'b1) pol2bad++;
    end
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [63:0] mk(input logic [5:0] res, input logic [15:0] src, input logic [31:0] pay);
    return {2'b00, res, 8'h00, src, pay};
  endfunction
  task automatic rx_send(input int which, input logic [63:0] p);
    if (which == 1) begin
      if1.peso = 1'b1;
      if1.pedo = p;
    end else begin
      if2.peso = 1'b1;
      if2.pedo = p;
    end
    @(negedge clk);
    if1.peso = 1'b0;
    if2.peso = 1'b0;
  endtask
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_idle(input int lim);
    int c = 0;
    while (busy != 3'b000 && c < lim) begin
      @(negedge clk);
      c++;
    end
    chk("idle_timeout", 64'(busy), 64'd0);
    @(negedge clk);
  endtask
  task automatic chk_cap0(input int base, input string tag);
    chk({tag, "_count"}, 64'(cap0.size() - base), 64'd3);
    for (int i = 0; i < 3 && base + i < cap0.size(); i++) chk({tag, "_pkt"}, cap0[base+i], exp0[i]);
  endtask
  initial begin
    int base, c, wexp;
    logic p;
    rv[0] = '{4'd0, 4'd1, 5'd4, 1'b0, 8'h01};
    rv[1] = '{4'd0, 4'd2, 5'd4, 1'b0, 8'h03};
    rv[2] = '{4'd0, 4'd3, 5'd4, 1'b1, 8'h01};
    rv[3] = '{4'd2, 4'd0, 5'd4, 1'b0, 8'h03};
    rv[4] = '{4'd0, 4'd4, 5'd8, 1'b0, 8'h0F};
    rv[5] = '{4'd5, 4'd1, 5'd8, 1'b0, 8'h0F};
    rv[6] = '{4'd1, 4'd6, 5'd8, 1'b1, 8'h07};
    rv[7] = '{4'd3, 4'd2, 5'd16, 1'b1, 8'h01};
    rv[8] = '{4'd0, 4'd8, 5'd16, 1'b0, 8'hFF};
    rv[9] = '{4'd1, 4'd0, 5'd2, 1'b0, 8'h01};
    exp0[0] = 64'h0101_0000_0000_0001;
    exp0[1] = 64'h0203_0000_0000_0002;
    exp0[2] = 64'h4301_0000_0000_0003;
    exp2[0] = 64'h8003_0002_0000_0000;
    exp2[1] = 64'hC101_0002_0000_0001;
    exp2[2] = 64'h8301_0002_0000_0003;
    if0.peri = 1'b1; if1.peri = 1'b1; if2.peri = 1'b1;
    if0.peso = 1'b0; if1.peso = 1'b0; if2.peso = 1'b0;
    if0.pedo = '0; if1.pedo = '0; if2.pedo = '0;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pesi", 64'(if0.pesi), 64'd0);
    chk("rst_pedi", if0.pedi, 64'd0);
    chk("rst_pero", 64'(if0.pero), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_phase", 64'(ph[0]), 64'd0);
    chk("rst_tx", 64'(tx[0]), 64'd0);
    chk("rst_rx", 64'(rx[0]), 64'd0);
    chk("rst_err", 64'(er[0]), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rc_src = rv[i].src;
      rc_dst = rv[i].dst;
      rc_n = rv[i].n;
      #1;
      chk($sformatf("route_%0d", i), {55'd0, rc_dir, rc_hop}, {55'd0, rv[i].dir, rv[i].hop});
    end
    @(negedge clk);
    rx_send(1, mk(6'd1, 16'd0, 32'd1));
    rx_send(1, mk(6'd1, 16'd2, 32'd1));
    rx_send(1, mk(6'd1, 16'd3, 32'd1));
    rx_send(1, mk(6'd1, 16'd0, 32'd2));
    rx_send(2, mk(6'd2, 16'd0, 32'd2));
    rx_send(2, mk(6'd2, 16'd1, 32'd2));
    rx_send(2, mk(6'd2, 16'd3, 32'd2));
    @(negedge clk);
    chk("u1_rx", 64'(rx[1]), 64'd4);
    chk("u1_err", 64'(er[1]), 64'd1);
    chk("u2_rx", 64'(rx[2]), 64'd3);
    chk("u2_err", 64'(er[2]), 64'd0);
    chk("u1_done_idle", 64'(done[1]), 64'd0);
    pulse_start();
    chk("run_busy", 64'(busy), 64'd7);
    repeat (3) @(negedge clk);
    chk("u1_done_midrun", 64'(done[1]), 64'd0);
    wait_idle(200);
    chk("u0_tx", 64'(tx[0]), 64'd3);
    chk_cap0(0, "u0_run1");
    chk("u0_pol", 64'(pol0bad), 64'd0);
    chk("u2_tx", 64'(tx[2]), 64'd3);
    chk("u2_count", 64'(cap2.size()), 64'd3);
    for (int i = 0; i < 3 && i < cap2.size(); i++) chk("u2_pkt", cap2[i], exp2[i]);
    chk("u2_pol", 64'(pol2bad), 64'd0);
    chk("u2_done", 64'(done[2]), 64'd1);
    chk("u0_phase_end", 64'(ph[0]), 64'd0);
    pulse_start();
    repeat (8) @(negedge clk);
    chk("done_start_ignored_busy", 64'(busy[0]), 64'd0);
    chk("done_start_ignored_tx", 64'(tx[0]), 64'd3);
    chk("u2_done_sticky", 64'(done[2]), 64'd1);
`ifdef RING_GATHER_LATENCY_EN
    chk("lat_max", 64'(lm[3]), 64'd5);
    chk("lat_sum", 64'(ls[3]), 64'd5);
    chk("lat_rx", 64'(rx3), 64'd3);
    chk("lat_err", 64'(er3), 64'd2);
`endif
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    if0.peri = 1'b0;
    base = cap0.size();
    pulse_start();
    repeat (20) @(negedge clk);
    chk("peri0_no_pesi", 64'(cap0.size() - base), 64'd0);
    chk("peri0_tx", 64'(tx[0]), 64'd0);
    p = polarity;
    if0.peri = 1'b1;
    wexp = p != 1'b0 ? 1 : 2;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!if0.pesi && c < 6);
    chk("slot_wait", 64'(c), 64'(wexp));
    chk("slot_pol", 64'(polarity), 64'd0);
    chk("slot_pkt", if0.pedi, exp0[0]);
    reset = 1'b0;
    #1;
    chk("async_pesi", 64'(if0.pesi), 64'd0);
    chk("async_pedi", if0.pedi, 64'd0);
    chk("async_pero", 64'(if0.pero), 64'd1);
    chk("async_busy", 64'(busy[0]), 64'd0);
    chk("async_tx", 64'(tx[0]), 64'd0);
    chk("async_phase", 64'(ph[0]), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    base = cap0.size();
    pulse_start();
    wait_idle(200);
    chk("rerun_tx", 64'(tx[0]), 64'd3);
    chk_cap0(base, "u0_rerun");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
